// File: rtl/decoder_pkg.sv
// Shared widths and payload type for the decoder bank.
//   W1/W2/W3    : select widths of the three channels
//   OH1/OH2/OH3 : one-hot output widths (2**Wn)
//   dec_t       : registered output payload (three one-hot codes + valid)
package decoder_pkg;

  localparam int unsigned W1  = 1;
  localparam int unsigned W2  = 2;
  localparam int unsigned W3  = 3;

  localparam int unsigned OH1 = 1 << W1;
  localparam int unsigned OH2 = 1 << W2;
  localparam int unsigned OH3 = 1 << W3;

  typedef struct packed {
    logic [OH3-1:0] out3;
    logic [OH2-1:0] out2;
    logic [OH1-1:0] out1;
    logic           valid;
  } dec_t;

endpackage : decoder_pkg

// File: rtl/onehot_decoder.sv
// Combinational N-to-2**N one-hot decoder.
//   sel    : N-bit unsigned select
//   onehot : 2**N-bit output, bit sel set, all others clear
module onehot_decoder #(
  parameter int unsigned N = 1
) (
  input  logic [N-1:0]      sel,
  output logic [(2**N)-1:0] onehot
);

  localparam int unsigned OW = 2**N;

  // Shift keeps unknown selects visible as unknown outputs rather than masking them.
  always_comb begin
    onehot = OW'(1) << sel;
  end

endmodule : onehot_decoder

// File: rtl/decoder_bank.sv
// Bank of three independent one-hot decoders (1:2, 2:4, 3:8).
//   REG_OUT   : 1 = outputs registered (1-cycle latency), 0 = combinational
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset (registered mode only)
//   in_valid  : qualifies a1/a2/a3
//   a1/a2/a3  : channel selects
//   out1/2/3  : one-hot decodes
//   out_valid : outputs hold a decode of valid inputs
module decoder_bank
  import decoder_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W1-1:0]  a1,
  input  logic [W2-1:0]  a2,
  input  logic [W3-1:0]  a3,
  output logic [OH1-1:0] out1,
  output logic [OH2-1:0] out2,
  output logic [OH3-1:0] out3,
  output logic           out_valid
);

  logic [OH1-1:0] dec1;
  logic [OH2-1:0] dec2;
  logic [OH3-1:0] dec3;

  onehot_decoder #(.N(W1)) u_dec1 (.sel(a1), .onehot(dec1));
  onehot_decoder #(.N(W2)) u_dec2 (.sel(a2), .onehot(dec2));
  onehot_decoder #(.N(W3)) u_dec3 (.sel(a3), .onehot(dec3));

  generate
    if (REG_OUT) begin : g_reg
      dec_t q;

      // Load on valid; on an idle cycle keep the codes and drop valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
        end else if (in_valid) begin
          q.out1  <= dec1;
          q.out2  <= dec2;
          q.out3  <= dec3;
          q.valid <= 1'b1;
        end else begin
          q.valid <= 1'b0;
        end
      end

      assign out1      = q.out1;
      assign out2      = q.out2;
      assign out3      = q.out3;
      assign out_valid = q.valid;
    end else begin : g_comb
      assign out1      = dec1;
      assign out2      = dec2;
      assign out3      = dec3;
      assign out_valid = in_valid;
    end
  endgenerate

endmodule : decoder_bank

// File: tb/tb_decoder_bank.sv
// Self-checking bench for decoder_bank (registered mode).
module tb_decoder_bank;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [0:0] a1;
  logic [1:0] a2;
  logic [2:0] a3;
  logic [1:0] out1;
  logic [3:0] out2;
  logic [7:0] out3;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  decoder_bank #(.REG_OUT(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a1        (a1),
    .a2        (a2),
    .a3        (a3),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       v;
    logic [0:0] s1;
    logic [1:0] s2;
    logic [2:0] s3;
    logic [1:0] e1;
    logic [3:0] e2;
    logic [7:0] e3;
    logic       ev;
  } vec_t;

  vec_t vec [10];

  // Reference model state: last loaded codes and valid flag.
  logic [1:0] m1;
  logic [3:0] m2;
  logic [7:0] m3;
  logic       mv;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e1, input logic [3:0] e2,
                         input logic [7:0] e3, input logic ev);
    chk({tag, ".out1"}, 32'(out1), 32'(e1));
    chk({tag, ".out2"}, 32'(out2), 32'(e2));
    chk({tag, ".out3"}, 32'(out3), 32'(e3));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    if (out_valid === 1'b1) begin
      chk({tag, ".onehot"}, 32'($countones({out1}) + $countones({out2}) + $countones({out3})),
          32'd3);
    end
  endtask

  // Model: decode is 2**select; idle cycle keeps codes, clears valid.
  task automatic model_step(input logic v, input logic [0:0] s1, input logic [1:0] s2,
                            input logic [2:0] s3);
    if (v) begin
      m1 = 2'(2 ** int'(s1));
      m2 = 4'(2 ** int'(s2));
      m3 = 8'(2 ** int'(s3));
      mv = 1'b1;
    end else begin
      mv = 1'b0;
    end
  endtask

  initial begin
    vec[0] = '{1'b1, 1'b0, 2'd0, 3'd0, 2'b01, 4'b0001, 8'b00000001, 1'b1};
    vec[1] = '{1'b1, 1'b1, 2'd1, 3'd1, 2'b10, 4'b0010, 8'b00000010, 1'b1};
    vec[2] = '{1'b1, 1'b0, 2'd2, 3'd2, 2'b01, 4'b0100, 8'b00000100, 1'b1};
    vec[3] = '{1'b1, 1'b1, 2'd3, 3'd3, 2'b10, 4'b1000, 8'b00001000, 1'b1};
    vec[4] = '{1'b1, 1'b0, 2'd0, 3'd4, 2'b01, 4'b0001, 8'b00010000, 1'b1};
    vec[5] = '{1'b1, 1'b1, 2'd1, 3'd5, 2'b10, 4'b0010, 8'b00100000, 1'b1};
    vec[6] = '{1'b0, 1'b0, 2'd2, 3'd2, 2'b10, 4'b0010, 8'b00100000, 1'b0};
    vec[7] = '{1'b1, 1'b0, 2'd3, 3'd6, 2'b01, 4'b1000, 8'b01000000, 1'b1};
    vec[8] = '{1'b1, 1'b1, 2'd0, 3'd7, 2'b10, 4'b0001, 8'b10000000, 1'b1};
    vec[9] = '{1'b0, 1'b0, 2'd0, 3'd0, 2'b10, 4'b0001, 8'b10000000, 1'b0};

    // Asynchronous reset with active inputs, before any clock edge.
    rst_n = 1'b1; in_valid = 1'b1; a1 = 1'b1; a2 = 2'd3; a3 = 3'd7;
    #1 rst_n = 1'b0;
    #1 chk_all("reset_async", 2'b00, 4'b0000, 8'h00, 1'b0);

    // A clock edge under reset must not load.
    @(posedge clk); #1;
    chk_all("reset_edge", 2'b00, 4'b0000, 8'h00, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: exhaustive decodes, back-to-back, hold on idle.
    for (int i = 0; i < 10; i++) begin
      in_valid = vec[i].v; a1 = vec[i].s1; a2 = vec[i].s2; a3 = vec[i].s3;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vec[i].e1, vec[i].e2, vec[i].e3, vec[i].ev);
      @(negedge clk);
    end

    // Mid-stream reset: load, then reset between valid cycles.
    in_valid = 1'b1; a1 = 1'b0; a2 = 2'd1; a3 = 3'd5;
    @(posedge clk); #1;
    chk_all("pre_rst", 2'b01, 4'b0010, 8'b00100000, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk_all("mid_rst", 2'b00, 4'b0000, 8'h00, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_rst_idle", 2'b00, 4'b0000, 8'h00, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; a1 = 1'b1; a2 = 2'd2; a3 = 3'd3;
    #1 chk_all("no_comb_path", 2'b00, 4'b0000, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk_all("post_rst_load", 2'b10, 4'b0100, 8'b00001000, 1'b1);
    @(negedge clk);

    // Randomized run against the model, with occasional resets.
    m1 = out1; m2 = 4'b0100; m3 = 8'b00001000; mv = 1'b1;
    m1 = 2'b10;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(39) == 0) begin
        rst_n = 1'b0;
        m1 = '0; m2 = '0; m3 = '0; mv = 1'b0;
        #1 chk_all("rand_rst", m1, m2, m3, mv);
        #1 rst_n = 1'b1;
      end
      in_valid = ($urandom_range(3) != 0);
      a1 = 1'($urandom);
      a2 = 2'($urandom);
      a3 = 3'($urandom);
      model_step(in_valid, a1, a2, a3);
      @(posedge clk); #1;
      chk_all("rand", m1, m2, m3, mv);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_decoder_bank
